// File: rtl/chiplet_types_pkg.sv
// Shared chiplet link types: flit layout, header formats, rx buffer FSM states.
// Header decode helpers map a header word to the number of flits that follow it.
// Pure types/functions; no state, no latency.
package chiplet_types_pkg;

    // One link flit: 8-bit sideband metadata plus a 32-bit payload word.
    typedef struct packed {
        logic [7:0]  meta;
        logic [31:0] payload;
    } flit_t;

    localparam int FLIT_BITS = $bits(flit_t);

    // Packet format code carried in header payload bits [31:28].
    typedef enum logic [3:0] {
        FMT_KOMMA_PACKET = 4'h0,
        FMT_SHORT_READ   = 4'h1,
        FMT_SHORT_WRITE  = 4'h2,
        FMT_LONG_READ    = 4'h3,
        FMT_LONG_WRITE   = 4'h4,
        FMT_MEM_RESP     = 4'h5,
        FMT_MSG          = 4'h6,
        FMT_SWITCH_CFG   = 4'h7
    } fmt_e;

    typedef enum logic [1:0] {
        RXB_IDLE = 2'd0,
        RXB_HDR  = 2'd1,
        RXB_BODY = 2'd2,
        RXB_DROP = 2'd3
    } rxbuf_state_e;

    // True for header formats the buffer knows how to size.
    function automatic logic fmt_known(logic [31:0] hdr);
        logic known;
        case (hdr[31:28])
            FMT_SHORT_READ, FMT_SHORT_WRITE, FMT_LONG_READ, FMT_LONG_WRITE,
            FMT_MEM_RESP, FMT_MSG, FMT_SWITCH_CFG: known = 1'b1;
            default:                               known = 1'b0;
        endcase
        return known;
    endfunction

    // Flits expected after the header. length7 is hdr[6:0], length4 is hdr[3:0].
    // Largest result is 1 + 127 + 1 = 129, so 8 bits always suffice.
    function automatic logic [7:0] pkt_flits(logic [31:0] hdr);
        logic [7:0] n;
        case (hdr[31:28])
            FMT_LONG_READ:          n = 8'd1;
            FMT_LONG_WRITE:         n = 8'd2 + {1'b0, hdr[6:0]};
            FMT_MEM_RESP, FMT_MSG:  n = 8'd1 + {1'b0, hdr[6:0]};
            FMT_SHORT_WRITE:        n = 8'd1 + {4'b0, hdr[3:0]};
            default:                n = 8'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rx_flit_fifo.sv
// Flit store with speculative write pointer, commit pointer and read pointer.
// Read data is combinational from the head entry (0-cycle read latency).
// Only committed flits are readable; rollback discards everything after commit.
module rx_flit_fifo #(
    parameter int DEPTH  = 64,
    parameter int FLIT_W = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [FLIT_W-1:0] wr_flit,
    input  logic              wr_last,
    input  logic              commit,
    input  logic              rollback,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [FLIT_W-1:0] rd_flit,
    output logic              rd_last,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     used;
    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  last_q;
    logic              wr_ok;
    logic              pop;

    // The extra MSB distinguishes full from empty when the index bits match.
    assign used     = wr_ptr_q - rd_ptr_q;
    assign full     = (used == PW'(DEPTH));
    assign rd_valid = (rd_ptr_q != commit_ptr_q);
    assign pop      = rd_en && rd_valid;
    assign wr_ok    = wr_en && !rollback && !full;

    // Output is forced to zero while nothing committed is waiting.
    assign rd_flit  = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign rd_last  = last_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state: rollback wins over a write in the same cycle.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (rollback) begin
            wr_ptr_d = commit_ptr_q;
        end else if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (commit) begin
            commit_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer and end-marker state, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            last_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            if (wr_ok) begin
                last_q[wr_ptr_q[AW-1:0]] <= wr_last;
            end
        end
    end

    // Flit storage; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_flit;
        end
    end

endmodule

// File: rtl/rx_packet_buffer.sv
// Receive packet buffer: stores each packet speculatively, commits or rolls back at eop.
// Output is the FIFO head with 0-cycle latency; ack/nack pulse one cycle after the decision.
// Consumer stalls via out_ready; a packet that does not fit is dropped, nacked and flagged.
module rx_packet_buffer
    import chiplet_types_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int FLIT_W = FLIT_BITS
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   sop_in,
    input  logic                   eop_in,
    input  logic                   flit_valid_in,
    input  logic [FLIT_W-1:0]      flit_in,
    input  logic                   err_in,
    output logic                   out_valid,
    output logic [FLIT_W-1:0]      out_flit,
    input  logic                   out_ready,
    output logic                   ack_req,
    output logic                   nack_req,
    output logic [$clog2(DEPTH):0] pkt_count,
    output logic                   overflow
);

    localparam int PW = $clog2(DEPTH) + 1;

    rxbuf_state_e  state_q, state_d;
    logic [7:0]    remaining_q, remaining_d;
    logic          ack_q, ack_d;
    logic          nack_q, nack_d;
    logic          overflow_q, overflow_d;
    logic [PW-1:0] pkt_count_q, pkt_count_d;

    logic          wr_en;
    logic          wr_last;
    logic          commit;
    logic          rollback;
    logic          drop;
    logic          fifo_full;
    logic          rd_last;
    logic          pop_last;
    logic          hdr_known;
    logic [7:0]    hdr_flits;

    assign hdr_known = fmt_known(flit_in[31:0]);
    assign hdr_flits = pkt_flits(flit_in[31:0]);

    rx_flit_fifo #(
        .DEPTH  (DEPTH),
        .FLIT_W (FLIT_W)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .wr_en    (wr_en),
        .wr_flit  (flit_in),
        .wr_last  (wr_last),
        .commit   (commit),
        .rollback (rollback),
        .rd_en    (out_ready),
        .rd_valid (out_valid),
        .rd_flit  (out_flit),
        .rd_last  (rd_last),
        .full     (fifo_full)
    );

    assign pop_last = out_valid && out_ready && rd_last;

    // Packet FSM decision: error > restart on sop > eop verdict > flit accept/drop.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        overflow_d  = overflow_q;
        ack_d       = 1'b0;
        nack_d      = 1'b0;
        wr_en       = 1'b0;
        wr_last     = 1'b0;
        commit      = 1'b0;
        rollback    = 1'b0;
        drop        = 1'b0;
        case (state_q)
            RXB_IDLE: begin
                if (sop_in) begin
                    state_d = RXB_HDR;
                end
            end
            RXB_HDR, RXB_BODY: begin
                if (err_in) begin
                    rollback = 1'b1;
                    nack_d   = 1'b1;
                    // An error coinciding with eop has nothing left to discard.
                    state_d  = eop_in ? RXB_IDLE : RXB_DROP;
                end else if (sop_in) begin
                    rollback = 1'b1;
                    nack_d   = 1'b1;
                    state_d  = RXB_HDR;
                end else if (eop_in) begin
                    // eop before any header is an empty packet and is refused.
                    if (state_q == RXB_BODY && remaining_q == 8'd0) begin
                        commit = 1'b1;
                        ack_d  = 1'b1;
                    end else begin
                        rollback = 1'b1;
                        nack_d   = 1'b1;
                    end
                    state_d = RXB_IDLE;
                end else if (flit_valid_in) begin
                    if (state_q == RXB_HDR && !hdr_known) begin
                        drop = 1'b1;
                    end else if (state_q == RXB_BODY && remaining_q == 8'd0) begin
                        drop = 1'b1;
                    end else if (fifo_full) begin
                        drop       = 1'b1;
                        overflow_d = 1'b1;
                    end else if (state_q == RXB_HDR) begin
                        wr_en       = 1'b1;
                        wr_last     = (hdr_flits == 8'd0);
                        remaining_d = hdr_flits;
                        state_d     = RXB_BODY;
                    end else begin
                        wr_en       = 1'b1;
                        wr_last     = (remaining_q == 8'd1);
                        remaining_d = remaining_q - 8'd1;
                    end
                end
            end
            RXB_DROP: begin
                if (eop_in) begin
                    state_d = RXB_IDLE;
                end
            end
            default: state_d = RXB_IDLE;
        endcase
        if (drop) begin
            rollback = 1'b1;
            nack_d   = 1'b1;
            state_d  = RXB_DROP;
        end
    end

    // Committed-packet count: a commit and a last-flit pop in one cycle cancel.
    always_comb begin
        pkt_count_d = pkt_count_q + PW'(commit) - PW'(pop_last);
    end

    // FSM state and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= RXB_IDLE;
            remaining_q <= '0;
            ack_q       <= 1'b0;
            nack_q      <= 1'b0;
            overflow_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ack_q       <= ack_d;
            nack_q      <= nack_d;
            overflow_q  <= overflow_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign ack_req   = ack_q;
    assign nack_req  = nack_q;
    assign overflow  = overflow_q;
    assign pkt_count = pkt_count_q;

endmodule
